// File: rtl/rca_seq_ctrl.sv
// Multi-precision adder sequencer: feeds one nibble per clock, LSB first, to an
// external 4-bit ripple-carry adder and chains the carry through a register.
module rca_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a_in,
  input  logic [4*NIBBLES-1:0] b_in,
  input  logic                 cin_in,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum_out,
  output logic                 cout_out,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  output logic                 add_cin,
  input  logic [3:0]           add_sum,
  input  logic                 add_carry
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  // Handshake: an operation is accepted on a rising edge where start=1 and
  // ready=1; start at any other time is dropped. done is a one-cycle pulse and
  // sum_out/cout_out are valid from that cycle until the next result loads.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic          carry_q, carry_d, cout_q, cout_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW+1:0] off;

  assign off = {idx_q, 2'b00};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin_in;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        add_a            = a_q[off +: 4];
        add_b            = b_q[off +: 4];
        add_cin          = carry_q;
        acc_d[off +: 4]  = add_sum;
        carry_d          = add_carry;
        if (idx_q == LAST_IDX) begin
          // acc_d already holds the top nibble from this cycle's adder output
          state_d = DONE;
          sum_d   = acc_d;
          cout_d  = add_carry;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign busy     = (state_q == RUN) || (state_q == DONE);
  assign done     = (state_q == DONE);
  assign sum_out  = sum_q;
  assign cout_out = cout_q;

endmodule
